slon5_collector: RTL and testbench

- Receive-side companion to slon5_m. Consumes the core's pipelined result stream (dout plus its dnum tag) and checks tag sequence continuity.
- Compares each digest against a programmable target and buffers qualifying hits in a small FIFO.
- Hits are presented downstream on a valid/ready interface.
- Sits between slon5_m and the host/readout logic.

---
 rtl/slon5_pkg.sv | 26 ++
 rtl/slon5_hit_fifo.sv | 59 +++++
 rtl/slon5_collector.sv | 138 +++++++++++++
 tb/tb_slon5_collector.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/slon5_pkg.sv
// Shared types for the slon5 core and its receive-side collector.
package slon5_pkg;

  localparam int DNUM_W = 32;
  localparam int DOUT_W = 64;

  typedef logic [DNUM_W-1:0] Dnum_t;
  typedef logic [DOUT_W-1:0] Dout_t;

  typedef struct packed {
    Dnum_t dnum;
    Dout_t dout;
  } Hit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } CollState_t;

  // Tag that must follow d; wraps modulo 2^DNUM_W.
  function automatic Dnum_t next_tag(input Dnum_t d);
    return d + DNUM_W'(1);
  endfunction

endpackage

// File: rtl/slon5_hit_fifo.sv
// Show-ahead FIFO of Hit_t; the head entry is visible whenever empty is low.
module slon5_hit_fifo
  import slon5_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  Hit_t din,
  input  logic pop,
  output Hit_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  Hit_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          wr_s;

  assign empty = (count_r == CW'(0));
  assign full  = (count_r == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_s = pop & ~empty;
  assign wr_s  = push & (~full | pop_s);
  assign head  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/slon5_collector.sv
// Receive-side collector for slon5_m: tag continuity check, target compare,
// and a buffered valid/ready hit stream with saturating statistics.
module slon5_collector
  import slon5_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CMP_W      = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  Dnum_t            dnum,
  input  Dout_t            dout,
  input  logic [CMP_W-1:0] target,
  output logic             hit_valid,
  input  logic             hit_ready,
  output Dnum_t            hit_dnum,
  output Dout_t            hit_dout,
  output logic             seq_err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  CollState_t state_r;
  Dnum_t      exp_r;
  logic       s1_valid_r;
  Dnum_t      s1_dnum_r;
  Dout_t      s1_dout_r;
  logic       s2_valid_r;
  Hit_t       s2_hit_r;
  logic       take_s;
  logic       cmp_hit_s;
  logic       pop_s;
  logic       full_s;
  logic       empty_s;
  logic       drop_s;
  logic       stored_s;
  Hit_t       head_s;

  assign take_s    = en & in_valid & (state_r != IDLE);
  assign cmp_hit_s = (s1_dout_r[DOUT_W-1 -: CMP_W] <= target);
  assign hit_valid = ~empty_s;
  assign pop_s     = hit_valid & hit_ready;
  assign drop_s    = s2_valid_r & full_s & ~pop_s;
  assign stored_s  = s2_valid_r & ~drop_s;
  assign hit_dnum  = head_s.dnum;
  assign hit_dout  = head_s.dout;

  // Collector FSM and tag sequence checker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      exp_r   <= DNUM_W'(0);
      seq_err <= 1'b0;
      err_cnt <= CNT_W'(0);
    end else if (!en) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: state_r <= SYNC;
        SYNC: begin
          if (in_valid) begin
            exp_r   <= next_tag(dnum);
            state_r <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            exp_r <= next_tag(dnum);
            if (dnum != exp_r) begin
              seq_err <= 1'b1;
              if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Two-stage pipeline: register the sample, then register the compare result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_dnum_r  <= DNUM_W'(0);
      s1_dout_r  <= DOUT_W'(0);
      s2_valid_r <= 1'b0;
      s2_hit_r   <= '0;
    end else begin
      s1_valid_r <= take_s;
      if (take_s) begin
        s1_dnum_r <= dnum;
        s1_dout_r <= dout;
      end
      s2_valid_r <= s1_valid_r & cmp_hit_s;
      if (s1_valid_r) begin
        s2_hit_r.dnum <= s1_dnum_r;
        s2_hit_r.dout <= s1_dout_r;
      end
    end
  end

  // Saturating hit and drop statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= CNT_W'(0);
      drop_cnt <= CNT_W'(0);
    end else begin
      if (stored_s && (hit_cnt != CNT_MAX)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (drop_s && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  slon5_hit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s2_valid_r),
    .din  (s2_hit_r),
    .pop  (pop_s),
    .head (head_s),
    .full (full_s),
    .empty(empty_s)
  );

endmodule

// File: tb/tb_slon5_collector.sv
// Scoreboard bench for slon5_collector: expected hits queued at drive time,
// compared in order as the DUT hands them downstream.
module tb_slon5_collector;
  import slon5_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int CMP_W      = 32;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  Dnum_t            dnum = '0;
  Dout_t            dout = '0;
  logic [CMP_W-1:0] target = '1;
  logic             hit_valid;
  logic             hit_ready = 1'b1;
  Dnum_t            hit_dnum;
  Dout_t            hit_dout;
  logic             seq_err;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] err_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  Hit_t exp_q[$];

  slon5_collector #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CMP_W     (CMP_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .dnum     (dnum),
    .dout     (dout),
    .target   (target),
    .hit_valid(hit_valid),
    .hit_ready(hit_ready),
    .hit_dnum (hit_dnum),
    .hit_dout (hit_dout),
    .seq_err  (seq_err),
    .hit_cnt  (hit_cnt),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One sample per call, presented at the falling edge; queue the hit if it should be stored.
  task automatic drive(input logic v, input Dnum_t d, input Dout_t o, input logic store);
    Hit_t h;
    @(negedge clk);
    in_valid = v;
    dnum     = d;
    dout     = o;
    if (v && store && (o[DOUT_W-1 -: CMP_W] <= target)) begin
      h.dnum = d;
      h.dout = o;
      exp_q.push_back(h);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    en        = 1'b0;
    in_valid  = 1'b0;
    hit_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_hit_valid", 64'(hit_valid), 64'd0);
    check_eq("rst_hit_dnum", 64'(hit_dnum), 64'd0);
    check_eq("rst_hit_dout", hit_dout, 64'd0);
    check_eq("rst_seq_err", 64'(seq_err), 64'd0);
    check_eq("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
  endtask

  task automatic start();
    @(negedge clk);
    en       = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (exp_q.size() != 0 || hit_valid); i++) @(negedge clk);
    check_eq("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every accepted head must match the oldest expected hit.
  always begin
    Hit_t h;
    @(negedge clk);
    #1;
    if (!rst && hit_valid && hit_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_hit", 64'(hit_dnum), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        h = exp_q.pop_front();
        check_eq("hit_dnum", 64'(hit_dnum), 64'(h.dnum));
        check_eq("hit_dout", hit_dout, h.dout);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Dnum_t tags3 [5];
    tags3 = '{32'd5, 32'd6, 32'd7, 32'd20, 32'd21};

    // 1: continuous stream, everything hits, 2-cycle latency
    do_reset();
    target = '1;
    start();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, Dnum_t'(i), {$urandom(), $urandom()}, 1'b1);
      if (i == 2) check_eq("lat_not_yet", 64'(hit_valid), 64'd0);
      if (i == 3) check_eq("lat_first", 64'(hit_valid), 64'd1);
    end
    idle(1);
    drain();
    check_eq("t1_hit_cnt", 64'(hit_cnt), 64'd100);
    check_eq("t1_seq_err", 64'(seq_err), 64'd0);

    // 2: threshold compare on dout MSBs
    do_reset();
    target = 32'd10;
    start();
    for (int i = 0; i < 32; i++) drive(1'b1, Dnum_t'(i), {32'(i), $urandom()}, 1'b1);
    idle(1);
    drain();
    check_eq("t2_hit_cnt", 64'(hit_cnt), 64'd11);

    // 3: tag discontinuity
    do_reset();
    target = '1;
    start();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tags3[i], {$urandom(), $urandom()}, 1'b1);
      if (i == 3) check_eq("t3_seq_before", 64'(seq_err), 64'd0);
      if (i == 4) check_eq("t3_seq_after", 64'(seq_err), 64'd1);
    end
    idle(1);
    drain();
    check_eq("t3_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("t3_seq_err", 64'(seq_err), 64'd1);

    // 4: tag wrap is continuous
    do_reset();
    start();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hFFFF_FFFE + Dnum_t'(i), {$urandom(), $urandom()}, 1'b1);
    idle(1);
    drain();
    check_eq("t4_seq_err", 64'(seq_err), 64'd0);
    check_eq("t4_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("t4_hit_cnt", 64'(hit_cnt), 64'd4);

    // 5a: overflow with no reader
    do_reset();
    hit_ready = 1'b0;
    start();
    for (int i = 0; i < 12; i++) drive(1'b1, Dnum_t'(i), {$urandom(), $urandom()}, (i < FIFO_DEPTH));
    idle(4);
    check_eq("t5_full_valid", 64'(hit_valid), 64'd1);
    check_eq("t5_hit_cnt", 64'(hit_cnt), 64'd8);
    check_eq("t5_drop_cnt", 64'(drop_cnt), 64'd4);
    hit_ready = 1'b1;
    drain();
    check_eq("t5_drop_after", 64'(drop_cnt), 64'd4);

    // 5b: push into a full FIFO while it is being popped
    do_reset();
    hit_ready = 1'b0;
    start();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, Dnum_t'(i), {$urandom(), $urandom()}, 1'b1);
      if (i == 10) hit_ready = 1'b1;
    end
    idle(1);
    drain();
    check_eq("t5b_drop_cnt", 64'(drop_cnt), 64'd0);
    check_eq("t5b_hit_cnt", 64'(hit_cnt), 64'd12);

    // 6: reset with samples in flight, then stay idle until enabled
    do_reset();
    start();
    drive(1'b1, 32'd0, {$urandom(), $urandom()}, 1'b0);
    drive(1'b1, 32'd1, {$urandom(), $urandom()}, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, Dnum_t'(i + 2), {$urandom(), $urandom()}, 1'b0);
    idle(4);
    check_eq("t6_no_valid", 64'(hit_valid), 64'd0);
    check_eq("t6_no_hits", 64'(hit_cnt), 64'd0);
    start();
    drive(1'b1, 32'd77, {$urandom(), $urandom()}, 1'b1);
    idle(1);
    drain();
    check_eq("t6_hit_cnt", 64'(hit_cnt), 64'd1);
    check_eq("t6_seq_err", 64'(seq_err), 64'd0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
